// File: rtl/card_pkg.sv
// Shared definitions for the card shoe: deck geometry, LFSR constants, FSM states
// and the card-width type used by the adder and the controller.
package card_pkg;
  localparam int          DECK_SIZE    = 52;
  localparam int          RANK_MAX     = 13;
  localparam int          CARD_W       = 4;
  localparam int          SEED_W       = 6;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [9:0]  LFSR_INIT_HI = 10'h2B1;

  typedef logic [CARD_W-1:0] card_t;

  typedef enum logic [2:0] {IDLE, FILL, SHUF, DEAL, RELEASE} state_e;

  // One Galois step: shift right, fold the taps in when a one falls off the end.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction
endpackage

// File: rtl/shuffle_lfsr.sv
// 16-bit Galois LFSR with a seed load; the high bits are a fixed non-zero
// constant so the register can never lock up at zero.
module shuffle_lfsr
  import card_pkg::*;
#(
  parameter int SEED_W = card_pkg::SEED_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [SEED_W-1:0] seed,
  input  logic              step,
  output logic [15:0]       state
);
  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load)      state_d = {LFSR_INIT_HI, seed};
    else if (step) state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= {LFSR_INIT_HI, {SEED_W{1'b0}}};
    else       state_q <= state_d;
  end

  assign state = state_q;
endmodule

// File: rtl/card_shoe.sv
// Card source for the blackjack game: refills a flop deck, Fisher-Yates shuffles
// it with rejection sampling from an LFSR, then deals one card per request.
module card_shoe
  import card_pkg::*;
#(
  parameter int DECK_SIZE = card_pkg::DECK_SIZE,
  parameter int CARD_W    = card_pkg::CARD_W,
  parameter int SEED_W    = card_pkg::SEED_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shuffle_start,
  output logic              shuffle_ready,
  input  logic [SEED_W-1:0] seed,
  input  logic              card_start,
  output logic              card_ready,
  output logic [CARD_W-1:0] card,
  output logic              card_overflow
);
  localparam int IDX_W = 6;
  localparam int PTR_W = $clog2(DECK_SIZE + 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    i_q, i_d;
  logic [CARD_W-1:0]   rank_q, rank_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CARD_W-1:0]   card_q, card_d;
  logic                ovf_q, ovf_d;
  logic                srdy_q, srdy_d;
  logic                crdy_q, crdy_d;
  logic [CARD_W-1:0]   deck_q [DECK_SIZE];
  logic [CARD_W-1:0]   deck_d [DECK_SIZE];

  logic                lfsr_load, lfsr_step_en;
  logic [15:0]         lfsr_state;
  logic [IDX_W-1:0]    j;
  logic [IDX_W-1:0]    rd_idx;

  shuffle_lfsr #(.SEED_W(SEED_W)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step_en),
    .state (lfsr_state)
  );

  // The swap index is taken from the value the LFSR is stepping to this cycle.
  assign j      = IDX_W'(lfsr_step(lfsr_state));
  assign rd_idx = IDX_W'(ptr_q);

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    rank_d       = rank_q;
    ptr_d        = ptr_q;
    card_d       = card_q;
    ovf_d        = ovf_q;
    srdy_d       = srdy_q;
    crdy_d       = crdy_q;
    deck_d       = deck_q;
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (shuffle_start) begin
          lfsr_load = 1'b1;
          srdy_d    = 1'b0;
          crdy_d    = 1'b0;
          i_d       = '0;
          rank_d    = CARD_W'(1);
          state_d   = FILL;
        end else if (card_start) begin
          crdy_d  = 1'b0;
          state_d = DEAL;
        end
      end
      FILL: begin
        deck_d[i_q] = rank_q;
        rank_d      = (rank_q == CARD_W'(RANK_MAX)) ? CARD_W'(1) : rank_q + 1'b1;
        if (i_q == IDX_W'(DECK_SIZE - 1)) state_d = SHUF;
        else                              i_d     = i_q + 1'b1;
      end
      SHUF: begin
        lfsr_step_en = 1'b1;
        if (j <= i_q) begin
          deck_d[i_q] = deck_q[j];
          deck_d[j]   = deck_q[i_q];
          i_d         = i_q - 1'b1;
          if (i_q == IDX_W'(1)) begin
            ptr_d   = '0;
            ovf_d   = 1'b0;
            state_d = RELEASE;
          end
        end
      end
      DEAL: begin
        if (ptr_q < PTR_W'(DECK_SIZE)) begin
          card_d = deck_q[rd_idx];
          ptr_d  = ptr_q + 1'b1;
        end else begin
          card_d = '0;
          ovf_d  = 1'b1;
        end
        state_d = RELEASE;
      end
      RELEASE: begin
        // Wait for both levels to drop so a held request cannot retrigger.
        if (!shuffle_start && !card_start) begin
          srdy_d  = 1'b1;
          crdy_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      rank_q  <= CARD_W'(1);
      ptr_q   <= PTR_W'(DECK_SIZE);
      card_q  <= '0;
      ovf_q   <= 1'b0;
      srdy_q  <= 1'b1;
      crdy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      rank_q  <= rank_d;
      ptr_q   <= ptr_d;
      card_q  <= card_d;
      ovf_q   <= ovf_d;
      srdy_q  <= srdy_d;
      crdy_q  <= crdy_d;
    end
  end

  always_ff @(posedge clk) begin
    deck_q <= deck_d;
  end

  assign shuffle_ready = srdy_q;
  assign card_ready    = crdy_q;
  assign card          = card_q;
  assign card_overflow = ovf_q;
endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe against a behavioural shuffle/deal model.
module tb_card_shoe;
  logic       clk = 1'b0;
  logic       reset, shuffle_start, card_start;
  logic       shuffle_ready, card_ready, card_overflow;
  logic [5:0] seed;
  logic [3:0] card;

  always #5 clk = ~clk;

  card_shoe dut (
    .clk(clk), .reset(reset), .shuffle_start(shuffle_start), .shuffle_ready(shuffle_ready),
    .seed(seed), .card_start(card_start), .card_ready(card_ready), .card(card),
    .card_overflow(card_overflow)
  );

  int n_chk = 0, n_pass = 0;
  int mdeck[52];
  int mptr;
  int seq_a[52];

  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Fresh ordered deck, then Fisher-Yates from the top with rejected samples.
  task automatic model_shuffle(input logic [5:0] sd, output int steps);
    logic [15:0] s;
    int i, j, t;
    for (int k = 0; k < 52; k++) mdeck[k] = (k % 13) + 1;
    s = {10'h2B1, sd};
    i = 51;
    steps = 0;
    while (i >= 1) begin
      s = m_step(s);
      steps++;
      j = int'(s[5:0]);
      if (j <= i) begin
        t = mdeck[i]; mdeck[i] = mdeck[j]; mdeck[j] = t;
        i--;
      end
    end
    mptr = 0;
  endtask

  task automatic do_shuffle(input logic [5:0] sd, input bit with_card, output int low);
    @(negedge clk);
    seed = sd; shuffle_start = 1'b1; card_start = with_card;
    @(negedge clk);
    shuffle_start = 1'b0; card_start = 1'b0;
    low = 0;
    while (!shuffle_ready && low < 5000) begin
      low++;
      @(negedge clk);
    end
  endtask

  task automatic do_deal(output logic [3:0] c);
    int n;
    @(negedge clk);
    card_start = 1'b1;
    @(negedge clk);
    card_start = 1'b0;
    n = 0;
    while (!card_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) $display("FAIL deal_timeout card_ready stuck low after %0d cycles, expected high", n);
    c = card;
  endtask

  task automatic test_reset;
    logic [3:0] c;
    reset = 1'b1; shuffle_start = 1'b0; card_start = 1'b0; seed = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_chk++; if (shuffle_ready !== 1'b1) $display("FAIL rst_srdy got %b exp 1", shuffle_ready); else n_pass++;
    n_chk++; if (card_ready !== 1'b1) $display("FAIL rst_crdy got %b exp 1", card_ready); else n_pass++;
    n_chk++; if (card !== 4'd0) $display("FAIL rst_card got %0d exp 0", card); else n_pass++;
    n_chk++; if (card_overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", card_overflow); else n_pass++;
    do_deal(c);
    n_chk++; if (c !== 4'd0) $display("FAIL unshuf_card got %0d exp 0", c); else n_pass++;
    n_chk++; if (card_overflow !== 1'b1) $display("FAIL unshuf_ovf got %b exp 1", card_overflow); else n_pass++;
  endtask

  task automatic test_shuffle_deal;
    int steps, low, hist[14];
    logic [3:0] c;
    model_shuffle(6'b001010, steps);
    do_shuffle(6'b001010, 1'b0, low);
    n_chk++; if (low != 53 + steps) $display("FAIL shuf_len got %0d exp %0d", low, 53 + steps); else n_pass++;
    n_chk++; if (low < 104 || low > 2000) $display("FAIL shuf_range got %0d exp 104..2000", low); else n_pass++;
    n_chk++; if (card_overflow !== 1'b0) $display("FAIL shuf_ovf_clr got %b exp 0", card_overflow); else n_pass++;
    for (int r = 0; r < 14; r++) hist[r] = 0;
    for (int k = 0; k < 52; k++) begin
      do_deal(c);
      seq_a[k] = int'(c);
      if (c <= 4'd13) hist[c]++;
      n_chk++; if (int'(c) != mdeck[k]) $display("FAIL deal_%0d got %0d exp %0d", k, c, mdeck[k]); else n_pass++;
    end
    for (int r = 1; r <= 13; r++) begin
      n_chk++; if (hist[r] != 4) $display("FAIL rank_%0d_count got %0d exp 4", r, hist[r]); else n_pass++;
    end
    n_chk++; if (card_overflow !== 1'b0) $display("FAIL full_deck_ovf got %b exp 0", card_overflow); else n_pass++;
    do_deal(c);
    n_chk++; if (c !== 4'd0) $display("FAIL deal53_card got %0d exp 0", c); else n_pass++;
    n_chk++; if (card_overflow !== 1'b1) $display("FAIL deal53_ovf got %b exp 1", card_overflow); else n_pass++;
  endtask

  task automatic test_repeat_seed;
    int steps, low, diff_b, diff_c, bad_c;
    logic [3:0] c;
    model_shuffle(6'b001010, steps);
    do_shuffle(6'b001010, 1'b0, low);
    diff_b = 0;
    for (int k = 0; k < 52; k++) begin
      do_deal(c);
      if (int'(c) != seq_a[k]) diff_b++;
    end
    n_chk++; if (diff_b != 0) $display("FAIL same_seed_diffs got %0d exp 0", diff_b); else n_pass++;
    model_shuffle(6'b010101, steps);
    do_shuffle(6'b010101, 1'b0, low);
    diff_c = 0; bad_c = 0;
    for (int k = 0; k < 52; k++) begin
      do_deal(c);
      if (int'(c) != seq_a[k]) diff_c++;
      if (int'(c) != mdeck[k]) bad_c++;
    end
    n_chk++; if (diff_c == 0) $display("FAIL other_seed_differs got %0d diffs exp >0", diff_c); else n_pass++;
    n_chk++; if (bad_c != 0) $display("FAIL other_seed_model got %0d diffs exp 0", bad_c); else n_pass++;
  endtask

  task automatic test_both_start;
    int steps, low;
    logic [3:0] prev, c;
    do_deal(prev);  // deck exhausted: known card 0 with overflow
    model_shuffle(6'b110011, steps);
    do_shuffle(6'b110011, 1'b1, low);
    n_chk++; if (low != 53 + steps) $display("FAIL both_shuf_len got %0d exp %0d", low, 53 + steps); else n_pass++;
    n_chk++; if (card !== prev) $display("FAIL both_card_held got %0d exp %0d", card, prev); else n_pass++;
    n_chk++; if (card_overflow !== 1'b0) $display("FAIL both_ovf got %b exp 0", card_overflow); else n_pass++;
    do_deal(c);
    n_chk++; if (int'(c) != mdeck[0]) $display("FAIL both_first_card got %0d exp %0d", c, mdeck[0]); else n_pass++;
    mptr = 1;
  endtask

  task automatic test_hold;
    int low_cnt;
    logic [3:0] c;
    @(negedge clk);
    card_start = 1'b1;
    @(negedge clk);
    n_chk++; if (card_ready !== 1'b0) $display("FAIL hold_ready_drop got %b exp 0", card_ready); else n_pass++;
    low_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (card_ready === 1'b0) low_cnt++;
    end
    n_chk++; if (low_cnt != 10) $display("FAIL hold_ready_low got %0d exp 10", low_cnt); else n_pass++;
    card_start = 1'b0;
    @(negedge clk);
    n_chk++; if (card_ready !== 1'b1) $display("FAIL hold_ready_rise got %b exp 1", card_ready); else n_pass++;
    n_chk++; if (int'(card) != mdeck[mptr]) $display("FAIL hold_card got %0d exp %0d", card, mdeck[mptr]); else n_pass++;
    mptr++;
    do_deal(c);
    n_chk++; if (int'(c) != mdeck[mptr]) $display("FAIL hold_next_card got %0d exp %0d", c, mdeck[mptr]); else n_pass++;
    mptr++;
  endtask

  task automatic test_random;
    int steps, low, cnt, bad;
    logic [5:0] sd;
    logic [3:0] c;
    for (int it = 0; it < 4; it++) begin
      sd = 6'($urandom);
      model_shuffle(sd, steps);
      do_shuffle(sd, 1'b0, low);
      n_chk++; if (low != 53 + steps) $display("FAIL rnd_len seed %0d got %0d exp %0d", sd, low, 53 + steps); else n_pass++;
      cnt = $urandom_range(1, 52);
      bad = 0;
      for (int k = 0; k < cnt; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_deal(c);
        if (int'(c) != mdeck[k]) bad++;
      end
      n_chk++; if (bad != 0) $display("FAIL rnd_deals seed %0d got %0d bad of %0d exp 0", sd, bad, cnt); else n_pass++;
    end
  endtask

  task automatic test_all_seeds;
    int steps, low, bad_len, worst;
    bad_len = 0; worst = 0;
    for (int s = 0; s < 64; s++) begin
      model_shuffle(6'(s), steps);
      do_shuffle(6'(s), 1'b0, low);
      if (low != 53 + steps) bad_len++;
      if (low > worst) worst = low;
    end
    n_chk++; if (bad_len != 0) $display("FAIL seeds_len got %0d wrong exp 0", bad_len); else n_pass++;
    n_chk++; if (worst > 2000) $display("FAIL seeds_bound got %0d exp <=2000", worst); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int steps, low, bad;
    logic [3:0] c;
    model_shuffle(6'b000111, steps);
    do_shuffle(6'b000111, 1'b0, low);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      do_deal(c);
      if (int'(c) != mdeck[k]) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL pre_reset_deals got %0d bad exp 0", bad); else n_pass++;
    @(negedge clk);
    seed = 6'b001010; shuffle_start = 1'b1;
    @(negedge clk);
    shuffle_start = 1'b0;
    repeat (60) @(negedge clk);  // past the 52 fill cycles, into the shuffle
    n_chk++; if (shuffle_ready !== 1'b0) $display("FAIL mid_shuf_busy got %b exp 0", shuffle_ready); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_chk++; if (shuffle_ready !== 1'b1 || card_ready !== 1'b1)
      $display("FAIL mid_rst_readies got %b%b exp 11", shuffle_ready, card_ready); else n_pass++;
    reset = 1'b0;
    do_deal(c);
    n_chk++; if (c !== 4'd0) $display("FAIL mid_rst_card got %0d exp 0", c); else n_pass++;
    n_chk++; if (card_overflow !== 1'b1) $display("FAIL mid_rst_ovf got %b exp 1", card_overflow); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_shuffle_deal;
    test_repeat_seed;
    test_both_start;
    test_hold;
    test_random;
    test_all_seeds;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/card_shoe.md
# card_shoe

Card-source responder for the blackjack game. It answers the controller's shuffle and card-request handshakes. It holds a 52-card deck in flops, refills it and performs a Fisher–Yates shuffle driven by a seeded LFSR, then deals one card per request until the deck is exhausted. It sits directly under the game controller and drives the card bus that the adder samples.

## Interface
- `DECK_SIZE`, 52: cards per deck; must be ≤ 64 because the swap index is a 6-bit sample.
- `CARD_W`, 4: card bus width; ranks are 1..13.
- `SEED_W`, 6: seed width.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset; one clock domain.
- `shuffle_start`  in  1  level request to refill and shuffle.
- `shuffle_ready`  out  1  high = idle; low = shuffle request accepted or in progress.
- `seed`  in  `SEED_W`  shuffle seed, sampled when a shuffle is accepted.
- `card_start`  in  1  level request for the next card.
- `card_ready`  out  1  high = idle and `card` valid; low = busy.
- `card`  out  `CARD_W`  dealt rank 1..13, or 0 when no card was available.
- `card_overflow`  out  1  sticky: a request was made with the deck empty.

## Operation
- States:
  - IDLE
  - FILL
  - SHUF
  - DEAL
  - RELEASE
- Reset (any state, mid-operation included):
  - state → IDLE; `shuffle_ready`=1, `card_ready`=1, `card`=0, `card_overflow`=0.
  - Deal pointer `ptr`=`DECK_SIZE`, so the deck counts as empty. Deck contents are don't-care.
  - An unshuffled shoe therefore answers with overflow.
- IDLE:
  - `shuffle_start`=1 → capture seed. LFSR ← {10'h2B1, seed}; the value is never zero.
  - Then drive both readies to 0, set i=0, go to FILL.
  - Otherwise `card_start`=1 → `card_ready`=0, go to DEAL.
  - If both starts are high in the same cycle, the shuffle wins and the card request is ignored.
- FILL, one cycle per slot:
  - deck[i] ← rank. The rank counter runs 1..13 and wraps 13→1.
  - After slot `DECK_SIZE`-1: i=`DECK_SIZE`-1, go to SHUF.
  - Result: each rank appears exactly 4 times.
- SHUF, each cycle:
  - Step the LFSR: 16-bit Galois, taps 0xB400. Let j = LFSR[5:0] after the step.
  - If j ≤ i: swap deck[i] and deck[j] in one cycle, then i--.
  - Otherwise reject the sample; nothing changes.
  - After the accept at i=1: `ptr`=0, `card_overflow`=0, go to RELEASE.
- DEAL, one cycle:
  - If `ptr`<`DECK_SIZE`: `card` ← deck[ptr], ptr++.
  - Otherwise: `card` ← 0, `card_overflow` ← 1.
  - Go to RELEASE.
- RELEASE:
  - Hold until `shuffle_start`=0 and `card_start`=0.
  - Then raise the ready that was lowered and go to IDLE.
  - This rule keeps a held level request from retriggering.
- `card` holds its value until the next DEAL or reset; a shuffle does not clear it.
- `card_overflow` clears only on shuffle completion or reset.

## Timing
- Card request:
  - `card_start` sampled high at edge k in IDLE → `card_ready`=0 after k.
  - `card` is updated at k+1.
  - `card_ready`=1 after the first edge ≥ k+2 at which both starts are low.
  - Minimum round trip is 2 cycles busy.
  - The controller style (drop start on seeing ready low) gives exactly edges k, k+1, k+2.
- Shuffle:
  - 1 accept cycle, 52 FILL cycles, then 51 accepted SHUF cycles plus rejects, then RELEASE.
  - Duration is deterministic for a given seed and bounded by the LFSR period. It must be ≤ 2000 cycles for all 64 seeds; verify this exhaustively.
- Requests in any state other than IDLE are ignored; there is no queuing.
- No combinational path from input to output; all outputs are registered.

## Structure
- Package `card_pkg`:
  - `DECK_SIZE`, `RANK_MAX`=13, `LFSR_TAPS`=16'hB400, `LFSR_INIT_HI`=10'h2B1.
  - State enum IDLE/FILL/SHUF/DEAL/RELEASE.
  - Card-width typedef, shared with the adder and the controller.
- Sub-module `shuffle_lfsr`:
  - Inputs: load, seed, step.
  - Output: a 16-bit state.
  - Reusable for the controller's seed generation.
- Deck storage is a `DECK_SIZE`×`CARD_W` flop array, because the single-cycle swap needs two read ports and two write ports.

## Test plan
- Reset, then check with no stimulus → `shuffle_ready`=1, `card_ready`=1, `card`=0, `card_overflow`=0. Then one `card_start` → `card`=0, `card_overflow`=1.
- Seed 6'b001010:
  - Shuffle → `shuffle_ready` low for ≥104 and ≤2000 cycles.
  - Then 52 deals → ranks 1..13 each exactly 4 times, `card_overflow`=0.
  - A 53rd deal → `card`=0, `card_overflow`=1.
- Shuffle twice with seed 6'b001010 → identical 52-card sequences. Seed 6'b010101 → a different sequence.
- `shuffle_start` and `card_start` raised in the same cycle → shuffle runs; `card` is unchanged and `ptr` is not advanced.
- Hold `card_start` high for 10 cycles after `card_ready` drops → exactly one card dealt; `card_ready` rises 1 cycle after release.
- Assert `reset` mid-SHUF after 3 deals of a prior deck → readies return to 1 the next cycle, and the next `card_start` → overflow=1.
